// File: rtl/uart_poll_master_pkg.sv
// UART MMIO register map, bit positions and the poll-master state encoding.
package uart_mmio_pkg;

  localparam logic [31:0] OFF_DATA    = 32'h0000_0000;
  localparam logic [31:0] OFF_STATUS  = 32'h0000_0004;
  localparam logic [31:0] OFF_CTRL    = 32'h0000_0008;
  localparam logic [31:0] OFF_BAUDDIV = 32'h0000_000C;

  localparam int unsigned ST_TX_READY  = 0;
  localparam int unsigned ST_RX_VALID  = 1;
  localparam int unsigned ST_OVERRUN   = 2;
  localparam int unsigned ST_FRAME_ERR = 3;

  localparam int unsigned CTRL_TX_EN    = 0;
  localparam int unsigned CTRL_RX_EN    = 1;
  localparam int unsigned CTRL_LOOPBACK = 2;
  localparam int unsigned CTRL_CLR_RX   = 3;
  localparam int unsigned CTRL_CLR_ERR  = 4;

  typedef enum logic [2:0] {
    S_INIT,
    S_GAP,
    S_POLL,
    S_DECIDE,
    S_CLR,
    S_RD,
    S_WR
  } state_e;

endpackage

// File: rtl/uart_poll_master_if.sv
// Shared AS_L/WE_L register bus between the poll master and the UART.
interface uart_poll_master_if;
  logic        AS_L;
  logic        WE_L;
  logic [31:0] Address;
  logic [31:0] BusDataOut;
  logic [31:0] BusDataIn;

  modport master (output AS_L, WE_L, Address, BusDataOut, input BusDataIn);
  modport slave  (input AS_L, WE_L, Address, BusDataOut, output BusDataIn);
endinterface

// File: rtl/uart_poll_master_sync_fifo.sv
// Small synchronous FIFO; DEPTH must be a power of two so pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/uart_poll_master.sv
// Bus initiator that polls the UART STATUS register and shuttles bytes between
// a TX FIFO / RX output register and the UART DATA register.
module uart_poll_master
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned TX_DEPTH  = 4,
  parameter int unsigned POLL_GAP  = 2,
  parameter logic [31:0] INIT_CTRL = 32'h0000_001B
) (
  input  logic                      clk,
  input  logic                      reset_n,
  uart_poll_master_if.master        bus,
  input  logic [7:0]                tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [7:0]                rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      ovr_err,
  output logic                      frm_err,
  input  logic                      clr_err
);
  localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (POLL_GAP > 1) ? GW'(POLL_GAP - 1) : '0;

  state_e        state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [3:0]    stat_q, stat_d;
  logic          as_l_q, as_l_d, we_l_q, we_l_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d, ovr_q, ovr_d, frm_q, frm_d;
  logic [7:0]    fifo_dout;
  logic          fifo_full, fifo_empty, fifo_pop;
  logic          bus_in_unused;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (tx_valid),
    .din     (tx_data),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign tx_ready       = !fifo_full;
  assign bus.AS_L       = as_l_q;
  assign bus.WE_L       = we_l_q;
  assign bus.Address    = addr_q;
  assign bus.BusDataOut = wdata_q;
  assign rx_data        = rx_data_q;
  assign rx_valid       = rx_valid_q;
  assign ovr_err        = ovr_q;
  assign frm_err        = frm_q;
  assign bus_in_unused  = ^bus.BusDataIn[31:8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_INIT;
      gap_q      <= '0;
      stat_q     <= '0;
      as_l_q     <= 1'b1;
      we_l_q     <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
      frm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      stat_q     <= stat_d;
      as_l_q     <= as_l_d;
      we_l_q     <= we_l_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ovr_q      <= ovr_d;
      frm_q      <= frm_d;
    end
  end

  // Bus outputs are registered from state_d, so each access state is its own
  // strobe cycle; S_INIT spends its first cycle arming the strobe. S_GAP is
  // never shorter than one cycle so strobes cannot be back to back.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      S_INIT: if (!as_l_q) begin
        state_d = S_GAP;
        gap_d   = GAP_LOAD;
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_POLL;
        else             gap_d   = gap_q - 1'b1;
      end
      S_POLL: state_d = S_DECIDE;
      S_DECIDE: begin
        if (stat_q[ST_FRAME_ERR:ST_OVERRUN] != 2'b00)    state_d = S_CLR;
        else if (stat_q[ST_RX_VALID] && !rx_valid_q)     state_d = S_RD;
        else if (stat_q[ST_TX_READY] && !fifo_empty)     state_d = S_WR;
        else begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end
      end
      S_CLR, S_RD, S_WR: begin
        state_d = S_GAP;
        gap_d   = GAP_LOAD;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    as_l_d     = 1'b1;
    we_l_d     = 1'b1;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_d)
      S_INIT: begin
        as_l_d  = 1'b0;
        we_l_d  = 1'b0;
        addr_d  = BASE_ADDR + OFF_CTRL;
        wdata_d = INIT_CTRL;
      end
      S_POLL: begin
        as_l_d = 1'b0;
        addr_d = BASE_ADDR + OFF_STATUS;
      end
      S_CLR: begin
        as_l_d  = 1'b0;
        we_l_d  = 1'b0;
        addr_d  = BASE_ADDR + OFF_STATUS;
        wdata_d = {28'h0, stat_q[ST_FRAME_ERR:ST_OVERRUN], 2'b00};
      end
      S_RD: begin
        as_l_d = 1'b0;
        addr_d = BASE_ADDR + OFF_DATA;
      end
      S_WR: begin
        as_l_d  = 1'b0;
        we_l_d  = 1'b0;
        addr_d  = BASE_ADDR + OFF_DATA;
        wdata_d = {24'h0, fifo_dout};
      end
      default: ;
    endcase

    stat_d     = (state_q == S_POLL) ? bus.BusDataIn[3:0] : stat_q;
    fifo_pop   = (state_q == S_WR);
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    if (state_q == S_RD) begin
      rx_data_d  = bus.BusDataIn[7:0];
      rx_valid_d = 1'b1;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    ovr_d = clr_err ? 1'b0 : ovr_q;
    frm_d = clr_err ? 1'b0 : frm_q;
    if (state_q == S_CLR) begin
      ovr_d = ovr_d | stat_q[ST_OVERRUN];
      frm_d = frm_d | stat_q[ST_FRAME_ERR];
    end
  end
endmodule

// File: tb/tb_uart_poll_master.sv
// Scoreboard bench: a UART register responder plus bus and RX monitors that
// compare every non-poll access and every RX handshake against queued expectations.
module tb_uart_poll_master;
  localparam logic [31:0] A_DATA = 32'h1000_0000;
  localparam logic [31:0] A_STAT = 32'h1000_0004;
  localparam logic [31:0] A_CTRL = 32'h1000_0008;

  typedef struct packed {
    logic        we_l;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       ovr_err, frm_err;
  logic       clr_err = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  acc_t       exp_q[$];
  logic [7:0] rx_exp_q[$];

  logic       st_tx = 1'b0;
  logic [7:0] rx_bytes [16];
  int rx_pushed = 0, rx_taken = 0;
  int ovr_req = 0, ovr_clr = 0, frm_req = 0, frm_clr = 0;
  logic [3:0] status;
  logic       prev_low = 1'b0;

  uart_poll_master_if bus_if ();

  uart_poll_master #(
    .BASE_ADDR (32'h1000_0000),
    .TX_DEPTH  (4),
    .POLL_GAP  (2),
    .INIT_CTRL (32'h0000_001B)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus_if.master),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .ovr_err  (ovr_err),
    .frm_err  (frm_err),
    .clr_err  (clr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART register responder: DATA read consumes a byte, STATUS write is W1C.
  assign status = {frm_req != frm_clr, ovr_req != ovr_clr, rx_pushed != rx_taken, st_tx};
  assign bus_if.BusDataIn =
    (!bus_if.AS_L && bus_if.WE_L && bus_if.Address == A_STAT) ? {28'h0, status} :
    (!bus_if.AS_L && bus_if.WE_L && bus_if.Address == A_DATA) ? {24'h0, rx_bytes[rx_taken[3:0]]} :
    32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (reset_n && !bus_if.AS_L) begin
      if (bus_if.WE_L && bus_if.Address == A_DATA && rx_pushed != rx_taken)
        rx_taken <= rx_taken + 1;
      if (!bus_if.WE_L && bus_if.Address == A_STAT) begin
        if (bus_if.BusDataOut[2]) ovr_clr <= ovr_req;
        if (bus_if.BusDataOut[3]) frm_clr <= frm_req;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic acc_t mk(input logic we_l, input logic [31:0] addr, input logic [31:0] data);
    acc_t a;
    a.we_l = we_l;
    a.addr = addr;
    a.data = data;
    return a;
  endfunction

  // Bus monitor: STATUS polls are background traffic, everything else is scored.
  always @(negedge clk) begin
    acc_t e;
    if (reset_n && !bus_if.AS_L) begin
      check("no_back_to_back", 32'(prev_low), 32'd0);
      if (!(bus_if.WE_L && bus_if.Address == A_STAT)) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_access: got we_l=%0b addr=%h data=%h expected none",
                   bus_if.WE_L, bus_if.Address, bus_if.BusDataOut);
        end else begin
          e = exp_q.pop_front();
          check("acc_we_l", 32'(bus_if.WE_L), 32'(e.we_l));
          check("acc_addr", bus_if.Address, e.addr);
          if (!e.we_l) check("acc_wdata", bus_if.BusDataOut, e.data);
        end
      end
    end
    prev_low <= reset_n && !bus_if.AS_L;
  end

  // RX monitor: every accepted byte must match the next expected byte.
  always @(negedge clk) begin
    logic [7:0] b;
    if (reset_n && rx_valid && rx_ready) begin
      if (rx_exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rx: got %h expected none", rx_data);
      end else begin
        b = rx_exp_q.pop_front();
        check("rx_byte", 32'(rx_data), 32'(b));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bus(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    tick();
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_rx(input string name, input int budget);
    int n = 0;
    while (rx_exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(rx_exp_q.size()), 32'd0);
  endtask

  task automatic wait_strobe(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (!bus_if.AS_L) seen = 1'b1;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  initial begin
    bit seen;
    int t0;

    // Reset values
    repeat (3) tick();
    check("rst_as_l", 32'(bus_if.AS_L), 32'd1);
    check("rst_we_l", 32'(bus_if.WE_L), 32'd1);
    check("rst_addr", bus_if.Address, 32'd0);
    check("rst_wdata", bus_if.BusDataOut, 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_ovr", 32'(ovr_err), 32'd0);
    check("rst_frm", 32'(frm_err), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);

    // INIT write then first poll after POLL_GAP idle cycles
    exp_q.push_back(mk(1'b0, A_CTRL, 32'h0000_001B));
    reset_n = 1'b1;
    wait_strobe(seen);
    check("init_strobe_seen", 32'(seen), 32'd1);
    t0 = cyc;
    wait_strobe(seen);
    check("poll_strobe_seen", 32'(seen), 32'd1);
    check("init_to_poll_gap", 32'(cyc - t0), 32'd3);
    check("poll_addr", bus_if.Address, A_STAT);
    check("poll_we_l", 32'(bus_if.WE_L), 32'd1);
    check("init_scored", 32'(exp_q.size()), 32'd0);

    // TX single byte
    tick();
    push_byte(8'h55);
    exp_q.push_back(mk(1'b0, A_DATA, 32'h0000_0055));
    st_tx = 1'b1;
    wait_bus("tx_55_written", 100);
    repeat (40) tick();
    check("tx_fifo_empty", 32'(tx_ready), 32'd1);

    // RX with consumer ready
    rx_ready = 1'b1;
    rx_bytes[0] = 8'hA3;
    exp_q.push_back(mk(1'b1, A_DATA, 32'h0));
    rx_exp_q.push_back(8'hA3);
    rx_pushed = 1;
    wait_bus("rx_a3_read", 100);
    wait_rx("rx_a3_taken", 50);
    repeat (20) tick();

    // RX with consumer stalled: rx_valid holds, no second DATA read
    rx_ready = 1'b0;
    rx_bytes[1] = 8'h3C;
    exp_q.push_back(mk(1'b1, A_DATA, 32'h0));
    rx_pushed = 2;
    wait_bus("rx_3c_read", 100);
    repeat (3) tick();
    check("rx_hold_valid", 32'(rx_valid), 32'd1);
    check("rx_hold_data", 32'(rx_data), 32'h3C);
    rx_bytes[2] = 8'h7E;
    rx_pushed = 3;
    repeat (40) tick();
    check("rx_still_valid", 32'(rx_valid), 32'd1);
    check("rx_still_data", 32'(rx_data), 32'h3C);
    exp_q.push_back(mk(1'b1, A_DATA, 32'h0));
    rx_exp_q.push_back(8'h3C);
    rx_exp_q.push_back(8'h7E);
    rx_ready = 1'b1;
    wait_bus("rx_7e_read", 100);
    wait_rx("rx_3c_7e_taken", 50);

    // STATUS=0x3 with a pending TX byte: DATA read precedes DATA write
    st_tx = 1'b0;
    tick();
    push_byte(8'h99);
    repeat (10) tick();
    rx_bytes[3] = 8'h11;
    exp_q.push_back(mk(1'b1, A_DATA, 32'h0));
    exp_q.push_back(mk(1'b0, A_DATA, 32'h0000_0099));
    rx_exp_q.push_back(8'h11);
    rx_pushed = 4;
    st_tx = 1'b1;
    wait_bus("rd_before_wr", 100);
    wait_rx("rx_11_taken", 50);

    // Overrun: W1C write 0x4, sticky flag, then clr_err
    ovr_req = ovr_req + 1;
    exp_q.push_back(mk(1'b0, A_STAT, 32'h0000_0004));
    wait_bus("w1c_ovr", 100);
    tick();
    check("ovr_set", 32'(ovr_err), 32'd1);
    check("frm_not_set", 32'(frm_err), 32'd0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    tick();
    check("ovr_cleared", 32'(ovr_err), 32'd0);

    // Frame error and overrun together: W1C data 0xC
    ovr_req = ovr_req + 1;
    frm_req = frm_req + 1;
    exp_q.push_back(mk(1'b0, A_STAT, 32'h0000_000C));
    wait_bus("w1c_both", 100);
    tick();
    check("both_ovr", 32'(ovr_err), 32'd1);
    check("both_frm", 32'(frm_err), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    tick();
    check("frm_cleared", 32'(frm_err), 32'd0);

    // Fill FIFO with TX blocked, 5th push ignored
    st_tx = 1'b0;
    tick();
    for (int i = 1; i <= 4; i++) begin
      check("fill_ready", 32'(tx_ready), 32'd1);
      push_byte(8'(i));
    end
    check("full_not_ready", 32'(tx_ready), 32'd0);
    push_byte(8'h05);
    check("fifth_ignored", 32'(tx_ready), 32'd0);

    // Reset during a strobe cycle
    wait_strobe(seen);
    check("strobe_before_reset", 32'(seen), 32'd1);
    reset_n = 1'b0;
    #1;
    check("reset_as_l", 32'(bus_if.AS_L), 32'd1);
    check("reset_addr", bus_if.Address, 32'd0);
    check("reset_flush", 32'(tx_ready), 32'd1);
    repeat (3) tick();
    exp_q.push_back(mk(1'b0, A_CTRL, 32'h0000_001B));
    st_tx = 1'b1;
    reset_n = 1'b1;
    wait_bus("init_rerun", 100);
    repeat (60) tick();
    check("post_reset_empty", 32'(tx_ready), 32'd1);
    check("final_bus_queue", 32'(exp_q.size()), 32'd0);
    check("final_rx_queue", 32'(rx_exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
